fft_frame_ctrl: RTL

Frame sequencer for the radix-2^2 SDF FFT pipeline.
- Collects N real audio samples from a valid/ready stream into an internal frame buffer.
- Replays the frame into the FFT as one contiguous N-cycle di_en burst, because the SDF stages require unbroken input enable.
- Counts and tags the N FFT outputs with bin index and end-of-frame.
- Sits between the audio front-end (windowing/decimation) and the FFT chain; the feature-extraction logic consumes its output.

---
 rtl/fft_frame_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the SDF FFT: buffers N samples, replays them as one unbroken
// di_en burst, then tags the N FFT outputs with bin index, last flag and a frame count.
module fft_frame_ctrl #(
  parameter int unsigned N       = 64,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 s_valid,
  input  logic [WIDTH-1:0]     s_data,
  output logic                 s_ready,
  output logic                 fft_di_en,
  output logic [WIDTH-1:0]     fft_di_re,
  output logic [WIDTH-1:0]     fft_di_im,
  input  logic                 fft_do_en,
  input  logic [WIDTH-1:0]     fft_do_re,
  input  logic [WIDTH-1:0]     fft_do_im,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_re,
  output logic [WIDTH-1:0]     out_im,
  output logic [$clog2(N)-1:0] out_index,
  output logic                 out_last,
  output logic                 busy,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic                 err_timeout
);

  localparam int unsigned AW = $clog2(N);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StFill, StStream, StDrain} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      st_cnt_q, st_cnt_d;
  logic [AW-1:0]    rd_cnt_q, rd_cnt_d;
  logic [TW-1:0]    dr_cnt_q, dr_cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             err_q, err_d;

  logic             di_en_q;
  logic [WIDTH-1:0] di_re_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_re_q, out_im_q;
  logic [AW-1:0]    out_index_q;

  logic [WIDTH-1:0] mem [N];

  logic          accept, issue, do_take, drain_done, drain_to;
  logic [AW-1:0] rd_addr;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    st_cnt_d    = st_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    dr_cnt_d    = dr_cnt_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;

    accept     = (state_q == StFill) && s_valid;
    // st_cnt 0 is a spacer cycle; counts 1..N each issue one buffer read
    issue      = (state_q == StStream) && (st_cnt_q != '0);
    rd_addr    = st_cnt_q[AW-1:0] - 1'b1;
    do_take    = (state_q == StDrain) && fft_do_en;
    drain_done = do_take && (rd_cnt_q == AW'(N - 1));
    drain_to   = (state_q == StDrain) && !drain_done && (dr_cnt_q == TW'(TIMEOUT - 1));

    unique case (state_q)
      StFill: begin
        if (accept) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == AW'(N - 1)) begin
            state_d  = StStream;
            st_cnt_d = '0;
          end
        end
      end
      StStream: begin
        st_cnt_d = st_cnt_q + 1'b1;
        if (st_cnt_q == (AW + 1)'(N)) begin
          state_d  = StDrain;
          dr_cnt_d = '0;
          rd_cnt_d = '0;
        end
      end
      StDrain: begin
        dr_cnt_d = dr_cnt_q + 1'b1;
        if (do_take) rd_cnt_d = rd_cnt_q + 1'b1;
        if (drain_done) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
          rd_cnt_d    = '0;
          state_d     = StFill;
        end else if (drain_to) begin
          err_d    = 1'b1;
          rd_cnt_d = '0;
          state_d  = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StFill;
      wr_ptr_q    <= '0;
      st_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      dr_cnt_q    <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
      di_en_q     <= 1'b0;
      di_re_q     <= '0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      st_cnt_q    <= st_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      dr_cnt_q    <= dr_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
      di_en_q     <= issue;
      if (issue) di_re_q <= mem[rd_addr];
      out_valid_q <= do_take;
      if (do_take) begin
        out_re_q    <= fft_do_re;
        out_im_q    <= fft_do_im;
        out_index_q <= rd_cnt_q;
      end
    end
  end

  // Frame buffer: no reset, contents are always rewritten before being replayed
  always_ff @(posedge clock) begin
    if (accept && !reset) mem[wr_ptr_q] <= s_data;
  end

  assign s_ready     = (state_q == StFill);
  assign busy        = (state_q != StFill);
  assign fft_di_en   = di_en_q;
  assign fft_di_re   = di_re_q;
  assign fft_di_im   = '0;
  assign out_valid   = out_valid_q;
  assign out_re      = out_re_q;
  assign out_im      = out_im_q;
  assign out_index   = out_index_q;
  assign out_last    = (out_index_q == AW'(N - 1));
  assign frame_cnt   = frame_cnt_q;
  assign err_timeout = err_q;

endmodule
